// File: rtl/simple_axi_to_axi_read_pkg.sv
// Shared definitions for the simple-to-AXI read bridge: FSM states,
// fixed AXI encodings and the burst-shaping limits.
package simple_axi_to_axi_read_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int MAX_BURST_BEATS = 256;
    localparam int BOUNDARY_4K     = 4096;
    localparam int WORD_BYTES      = 4;

endpackage

// File: rtl/simple_axi_read_burst_calc.sv
// Burst sizing: picks the beat count of the next burst so that it never
// exceeds the remaining request, the AXI4 256-beat limit, or the 4 KB page.
module simple_axi_read_burst_calc
    import simple_axi_to_axi_read_pkg::*;
#(
    parameter int LEN_W     = 20,
    parameter int AXI_LEN_W = 8
)
(
    input  logic [9:0]           word_off_i,
    input  logic [LEN_W-1:0]     remaining_i,
    output logic [AXI_LEN_W:0]   beats_o,
    output logic [AXI_LEN_W-1:0] arlen_o
);

    localparam int ROOM_W = $clog2(BOUNDARY_4K / WORD_BYTES) + 1;
    localparam int CNT_W  = AXI_LEN_W + 1;

    logic [ROOM_W-1:0] room;
    logic [CNT_W-1:0]  cap;

    // Take the smallest of page room, burst limit and remaining beats
    always_comb begin
        room = ROOM_W'(BOUNDARY_4K / WORD_BYTES) - ROOM_W'(word_off_i);
        if (room >= ROOM_W'(MAX_BURST_BEATS)) begin
            cap = CNT_W'(MAX_BURST_BEATS);
        end else begin
            cap = room[CNT_W-1:0];
        end
        if (remaining_i < LEN_W'(cap)) begin
            beats_o = remaining_i[CNT_W-1:0];
        end else begin
            beats_o = cap;
        end
        arlen_o = beats_o[AXI_LEN_W-1:0] - AXI_LEN_W'(1);
    end

endmodule

// File: rtl/simple_axi_to_axi_read.sv
// Simple read master to AXI4 read bridge. Splits one byte-length request into
// page-safe INCR bursts and forwards each returned word to the simple side.
module simple_axi_to_axi_read
    import simple_axi_to_axi_read_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int LEN_W      = 20
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m_rvalid_i,
    input  logic [AXI_ADDR_W-1:0] m_raddr_i,
    input  logic [LEN_W-1:0]      m_rlen_i,
    output logic                  m_rready_o,
    output logic [AXI_DATA_W-1:0] m_rdata_o,
    output logic                  m_rlast_o,
    output logic                  error_o,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    output logic [AXI_ADDR_W-1:0] axi_araddr_o,
    output logic [AXI_LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [1:0]            axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [2:0]            axi_arprot_o,
    output logic [3:0]            axi_arqos_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    input  logic [AXI_DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);

    state_t                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
    logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [AXI_LEN_W:0]    burst_n_q, burst_n_d;
    logic                  arvalid_q, arvalid_d;
    logic                  error_q, error_d;
    logic                  zero_len_q, zero_len_d;

    logic [AXI_LEN_W:0]    calc_beats;
    logic [AXI_LEN_W-1:0]  calc_arlen;
    logic [LEN_W-1:0]      req_beats;
    logic                  beat_fire;
    logic                  last_beat;
    logic                  zero_pulse;
    logic                  unused_inputs;

    simple_axi_read_burst_calc #(
        .LEN_W     (LEN_W),
        .AXI_LEN_W (AXI_LEN_W)
    ) u_burst_calc (
        .word_off_i  (addr_q[11:2]),
        .remaining_i (remaining_q),
        .beats_o     (calc_beats),
        .arlen_o     (calc_arlen)
    );

    // Byte length to word count, rounding a trailing partial word up; zero stays zero
    always_comb begin
        if (m_rlen_i == '0) begin
            req_beats = '0;
        end else begin
            req_beats = ((m_rlen_i - LEN_W'(1)) >> 2) + LEN_W'(1);
        end
    end

    assign beat_fire  = (state_q == ST_DATA) && axi_rvalid_i;
    assign last_beat  = (beat_cnt_q == arlen_q);
    assign zero_pulse = (state_q == ST_GAP) && zero_len_q;

    assign m_rready_o = beat_fire || zero_pulse;
    assign m_rlast_o  = (beat_fire && last_beat && (remaining_q == '0)) || zero_pulse;
    assign m_rdata_o  = zero_pulse ? '0 : axi_rdata_i;
    assign error_o    = error_q;

    assign axi_arid_o    = '0;
    assign axi_araddr_o  = araddr_q;
    assign axi_arlen_o   = arlen_q;
    assign axi_arsize_o  = SIZE_4B;
    assign axi_arburst_o = BURST_INCR;
    assign axi_arlock_o  = 2'b00;
    assign axi_arcache_o = 4'b0000;
    assign axi_arprot_o  = 3'b000;
    assign axi_arqos_o   = 4'b0000;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = (state_q == ST_DATA);

    assign unused_inputs = ^{axi_rid_i, m_raddr_i[1:0]};

    // Next-state and next-register values for the request sequencer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        araddr_d    = araddr_q;
        remaining_d = remaining_q;
        arlen_d     = arlen_q;
        beat_cnt_d  = beat_cnt_q;
        burst_n_d   = burst_n_q;
        arvalid_d   = arvalid_q;
        error_d     = error_q;
        zero_len_d  = zero_len_q;
        case (state_q)
            ST_IDLE: begin
                if (m_rvalid_i) begin
                    addr_d      = {m_raddr_i[AXI_ADDR_W-1:2], 2'b00};
                    remaining_d = req_beats;
                    error_d     = 1'b0;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                if (remaining_q == '0) begin
                    zero_len_d = 1'b1;
                    state_d    = ST_GAP;
                end else begin
                    araddr_d  = addr_q;
                    arlen_d   = calc_arlen;
                    burst_n_d = calc_beats;
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi_arready_i) begin
                    arvalid_d   = 1'b0;
                    remaining_d = remaining_q - LEN_W'(burst_n_q);
                    addr_d      = addr_q + AXI_ADDR_W'({burst_n_q, 2'b00});
                    beat_cnt_d  = '0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi_rvalid_i) begin
                    beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
                    if ((axi_rresp_i != RESP_OKAY) || (axi_rlast_i != last_beat)) begin
                        error_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                zero_len_d = 1'b0;
                if (remaining_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any burst in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            araddr_q    <= '0;
            remaining_q <= '0;
            arlen_q     <= '0;
            beat_cnt_q  <= '0;
            burst_n_q   <= '0;
            arvalid_q   <= 1'b0;
            error_q     <= 1'b0;
            zero_len_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            araddr_q    <= araddr_d;
            remaining_q <= remaining_d;
            arlen_q     <= arlen_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_n_q   <= burst_n_d;
            arvalid_q   <= arvalid_d;
            error_q     <= error_d;
            zero_len_q  <= zero_len_d;
        end
    end

endmodule

// File: tb/tb_simple_axi_to_axi_read.sv
// Bench for simple_axi_to_axi_read: the bench plays both the simple master
// and an AXI slave backed by an address-hashed memory, and compares every
// AR and every returned word against a request-level reference model.
module tb_simple_axi_to_axi_read;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m_rvalid_i;
   logic [31:0] m_raddr_i;
   logic [19:0] m_rlen_i;
   logic        m_rready_o;
   logic [31:0] m_rdata_o;
   logic        m_rlast_o;
   logic        error_o;
   logic [0:0]  axi_arid_o;
   logic [31:0] axi_araddr_o;
   logic [7:0]  axi_arlen_o;
   logic [2:0]  axi_arsize_o;
   logic [1:0]  axi_arburst_o;
   logic [1:0]  axi_arlock_o;
   logic [3:0]  axi_arcache_o;
   logic [2:0]  axi_arprot_o;
   logic [3:0]  axi_arqos_o;
   logic        axi_arvalid_o;
   logic        axi_arready_i;
   logic [0:0]  axi_rid_i;
   logic [31:0] axi_rdata_i;
   logic [1:0]  axi_rresp_i;
   logic        axi_rlast_i;
   logic        axi_rvalid_i;
   logic        axi_rready_o;

   int vecCount = 0;
   int missCount = 0;
   string curTag = "init";

   logic [31:0] expArAddr[$];
   logic [7:0]  expArLen[$];
   logic [31:0] expData[$];
   int          expBeatTotal;
   logic [31:0] obsArAddr[$];
   logic [7:0]  obsArLen[$];
   int          obsBeats;
   int          obsLastCount;

   typedef struct {
      logic [31:0] addr;
      logic [19:0] len;
      int          arDelay;
      int          gapPct;
      int          errBeat;
      int          nBursts;
      int          nBeats;
      logic [31:0] ar0Addr;
      logic [7:0]  ar0Len;
      logic [31:0] ar1Addr;
      logic [7:0]  ar1Len;
   } vec_t;

   localparam int NUM_VEC = 8;
   vec_t tbl[NUM_VEC];

   simple_axi_to_axi_read dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .m_rvalid_i    (m_rvalid_i),
      .m_raddr_i     (m_raddr_i),
      .m_rlen_i      (m_rlen_i),
      .m_rready_o    (m_rready_o),
      .m_rdata_o     (m_rdata_o),
      .m_rlast_o     (m_rlast_o),
      .error_o       (error_o),
      .axi_arid_o    (axi_arid_o),
      .axi_araddr_o  (axi_araddr_o),
      .axi_arlen_o   (axi_arlen_o),
      .axi_arsize_o  (axi_arsize_o),
      .axi_arburst_o (axi_arburst_o),
      .axi_arlock_o  (axi_arlock_o),
      .axi_arcache_o (axi_arcache_o),
      .axi_arprot_o  (axi_arprot_o),
      .axi_arqos_o   (axi_arqos_o),
      .axi_arvalid_o (axi_arvalid_o),
      .axi_arready_i (axi_arready_i),
      .axi_rid_i     (axi_rid_i),
      .axi_rdata_i   (axi_rdata_i),
      .axi_rresp_i   (axi_rresp_i),
      .axi_rlast_i   (axi_rlast_i),
      .axi_rvalid_i  (axi_rvalid_i),
      .axi_rready_o  (axi_rready_o)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk_i = ~clk_i;

   // Contents of the slave memory: a fixed hash of the byte address
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
   endfunction

   // One comparison; every failure prints a single line
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s (%s): got 0x%08h, expected 0x%08h", name, curTag, act, exp);
      end
   endtask

   // Request-level model: expected AR list and word stream for one request
   task automatic buildModel(input logic [31:0] addr, input logic [19:0] len);
      logic [31:0] a;
      int unsigned rem;
      int unsigned n;
      int unsigned room;
      expArAddr.delete();
      expArLen.delete();
      expData.delete();
      a = addr & 32'hFFFF_FFFC;
      rem = (len == 0) ? 0 : (int'(len) + 3) / 4;
      expBeatTotal = (len == 0) ? 1 : int'(rem);
      if (len == 0) expData.push_back(32'h0);
      while (rem > 0) begin
         room = (4096 - int'(a[11:0])) / 4;
         n = rem;
         if (n > 256) n = 256;
         if (n > room) n = room;
         expArAddr.push_back(a);
         expArLen.push_back(8'(n - 1));
         for (int i = 0; i < int'(n); i++) expData.push_back(memWord(a + 32'(4 * i)));
         a = a + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   // Runs one request end to end as simple master and AXI slave; optional reset mid-burst
   task automatic applyStimulus(input logic [31:0] addr, input logic [19:0] len, input int arDelay,
                                input int gapPct, input int errBeat, input int resetAtBeat);
      int cyc = 0;
      int arIdx = 0;
      int beatIdx = 0;
      int burstBeat = 0;
      int lastBeatCyc = -100;
      int arWait = 0;
      int tail = 0;
      logic arSeen = 1'b0;
      logic burstActive = 1'b0;
      logic arHsPrev = 1'b0;
      logic rHsPrev = 1'b0;
      logic lastPrev = 1'b0;
      logic lastSeen = 1'b0;
      logic aborted = 1'b0;
      logic rvalidDrv;
      logic expLast;
      logic [31:0] curAraddr = 32'h0;
      logic [31:0] burstAddr = 32'h0;
      logic [31:0] expWord;
      logic [7:0]  curArlen = 8'h0;
      logic [7:0]  burstLen = 8'h0;

      buildModel(addr, len);
      obsArAddr.delete();
      obsArLen.delete();
      obsBeats = 0;
      obsLastCount = 0;

      @(negedge clk_i);
      m_rvalid_i = 1'b1;
      m_raddr_i  = addr;
      m_rlen_i   = len;

      while (tail < 3 && cyc < 5000 && !aborted) begin
         @(negedge clk_i);
         cyc++;
         if (arHsPrev) begin
            burstActive = 1'b1;
            burstBeat = 0;
            burstAddr = curAraddr;
            burstLen = curArlen;
            arSeen = 1'b0;
         end
         if (rHsPrev) begin
            if (burstBeat == int'(burstLen)) begin
               burstActive = 1'b0;
               lastBeatCyc = cyc - 1;
            end
            burstBeat++;
            beatIdx++;
         end
         if (lastPrev) begin
            m_rvalid_i = 1'b0;
            lastSeen = 1'b1;
         end
         if (lastSeen) tail++;
         if (cyc == 1) checkOutput("error_clear", 32'(error_o), 32'h0);

         if (resetAtBeat >= 0 && beatIdx == resetAtBeat) begin
            axi_arready_i = 1'b0;
            axi_rvalid_i = 1'b1;
            axi_rlast_i = 1'b0;
            rst_i = 1'b0;
            #1;
            checkOutput("rst_arvalid", 32'(axi_arvalid_o), 32'h0);
            checkOutput("rst_araddr", axi_araddr_o, 32'h0);
            checkOutput("rst_arlen", 32'(axi_arlen_o), 32'h0);
            checkOutput("rst_rready", 32'(axi_rready_o), 32'h0);
            checkOutput("rst_m_rready", 32'(m_rready_o), 32'h0);
            checkOutput("rst_m_rlast", 32'(m_rlast_o), 32'h0);
            checkOutput("rst_error", 32'(error_o), 32'h0);
            axi_rvalid_i = 1'b0;
            m_rvalid_i = 1'b0;
            aborted = 1'b1;
         end else begin
            axi_arready_i = 1'b0;
            if (axi_arvalid_o) begin
               if (!arSeen) begin
                  arSeen = 1'b1;
                  curAraddr = axi_araddr_o;
                  curArlen = axi_arlen_o;
                  arWait = arDelay;
                  obsArAddr.push_back(axi_araddr_o);
                  obsArLen.push_back(axi_arlen_o);
                  if (arIdx < expArAddr.size()) begin
                     checkOutput("araddr", axi_araddr_o, expArAddr[arIdx]);
                     checkOutput("arlen", 32'(axi_arlen_o), 32'(expArLen[arIdx]));
                  end else begin
                     checkOutput("extra_ar", 32'h1, 32'h0);
                  end
                  checkOutput("ar_const", {axi_arid_o, axi_arsize_o, axi_arburst_o, axi_arlock_o,
                                           axi_arcache_o, axi_arprot_o, axi_arqos_o},
                              {1'b0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0});
                  if (arIdx == 0) checkOutput("ar_latency", cyc, 32'd2);
                  else checkOutput("ar_gap", cyc - lastBeatCyc, 32'd3);
                  arIdx++;
               end else begin
                  checkOutput("araddr_stable", axi_araddr_o, curAraddr);
                  checkOutput("arlen_stable", 32'(axi_arlen_o), 32'(curArlen));
               end
               if (arWait == 0) axi_arready_i = 1'b1;
               else arWait--;
            end

            rvalidDrv = burstActive && ($urandom_range(99) >= gapPct);
            axi_rvalid_i = rvalidDrv;
            axi_rdata_i = rvalidDrv ? memWord(burstAddr + 32'(4 * burstBeat)) : $urandom;
            axi_rlast_i = rvalidDrv && (burstBeat == int'(burstLen));
            axi_rresp_i = (rvalidDrv && beatIdx == errBeat) ? 2'b10 : 2'b00;
            #1;
            if (rvalidDrv) checkOutput("axi_rready", 32'(axi_rready_o), 32'h1);
            if (m_rready_o) begin
               obsBeats++;
               if (expData.size() == 0) begin
                  checkOutput("extra_beat", 32'h1, 32'h0);
               end else begin
                  expLast = (expData.size() == 1);
                  expWord = expData.pop_front();
                  checkOutput("m_rdata", m_rdata_o, expWord);
                  checkOutput("m_rlast", 32'(m_rlast_o), 32'(expLast));
               end
            end else if (rvalidDrv) begin
               checkOutput("missed_beat", 32'(m_rready_o), 32'h1);
            end
            if (m_rlast_o) obsLastCount++;
            arHsPrev = axi_arvalid_o && axi_arready_i;
            rHsPrev = rvalidDrv && axi_rready_o;
            lastPrev = m_rready_o && m_rlast_o;
         end
      end

      axi_arready_i = 1'b0;
      axi_rvalid_i = 1'b0;
      axi_rlast_i = 1'b0;
      axi_rresp_i = 2'b00;
      if (aborted) begin
         @(negedge clk_i);
         rst_i = 1'b1;
         @(negedge clk_i);
         checkOutput("post_rst_idle", {30'h0, axi_arvalid_o, axi_rready_o}, 32'h0);
      end else begin
         checkOutput("timeout", 32'(cyc >= 5000), 32'h0);
         checkOutput("beat_count", obsBeats, expBeatTotal);
         checkOutput("rlast_count", obsLastCount, 32'd1);
         checkOutput("ar_count", obsArAddr.size(), expArAddr.size());
         checkOutput("error_o", 32'(error_o), 32'(errBeat >= 0 && errBeat < expBeatTotal));
      end
   endtask

   initial begin
      tbl[0] = '{32'h0000_1000, 20'd16,   0,  0, -1, 1, 4,   32'h1000, 8'd3,   32'h0,    8'd0};
      tbl[1] = '{32'h0000_0000, 20'd1500, 1, 20, -1, 2, 375, 32'h0000, 8'd255, 32'h0400, 8'd118};
      tbl[2] = '{32'h0000_0FF8, 20'd32,   0,  0, -1, 2, 8,   32'h0FF8, 8'd1,   32'h1000, 8'd5};
      tbl[3] = '{32'h0000_2000, 20'd6,    0,  0, -1, 1, 2,   32'h2000, 8'd1,   32'h0,    8'd0};
      tbl[4] = '{32'h0000_3000, 20'd0,    0,  0, -1, 0, 1,   32'h0,    8'd0,   32'h0,    8'd0};
      tbl[5] = '{32'h0000_4000, 20'd64,   5, 40, -1, 1, 16,  32'h4000, 8'd15,  32'h0,    8'd0};
      tbl[6] = '{32'h0000_5000, 20'd40,   2, 30,  2, 1, 10,  32'h5000, 8'd9,   32'h0,    8'd0};
      tbl[7] = '{32'h0000_6002, 20'd8,    0,  0, -1, 1, 2,   32'h6000, 8'd1,   32'h0,    8'd0};

      rst_i = 1'b0;
      m_rvalid_i = 1'b0;
      m_raddr_i = 32'h0;
      m_rlen_i = 20'h0;
      axi_arready_i = 1'b0;
      axi_rid_i = 1'b0;
      axi_rdata_i = 32'h0;
      axi_rresp_i = 2'b00;
      axi_rlast_i = 1'b0;
      axi_rvalid_i = 1'b0;

      repeat (3) @(negedge clk_i);
      curTag = "reset";
      checkOutput("reset_arvalid", 32'(axi_arvalid_o), 32'h0);
      checkOutput("reset_araddr", axi_araddr_o, 32'h0);
      checkOutput("reset_arlen", 32'(axi_arlen_o), 32'h0);
      checkOutput("reset_rready", 32'(axi_rready_o), 32'h0);
      checkOutput("reset_m_rready", 32'(m_rready_o), 32'h0);
      checkOutput("reset_m_rlast", 32'(m_rlast_o), 32'h0);
      checkOutput("reset_error", 32'(error_o), 32'h0);
      rst_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < NUM_VEC; i++) begin
         curTag = $sformatf("table%0d", i);
         applyStimulus(tbl[i].addr, tbl[i].len, tbl[i].arDelay, tbl[i].gapPct, tbl[i].errBeat, -1);
         checkOutput("tbl_ar_count", obsArAddr.size(), tbl[i].nBursts);
         checkOutput("tbl_beats", obsBeats, tbl[i].nBeats);
         if (tbl[i].nBursts > 0) begin
            checkOutput("tbl_ar0_addr", (obsArAddr.size() > 0) ? obsArAddr[0] : 32'hFFFF_FFFF, tbl[i].ar0Addr);
            checkOutput("tbl_ar0_len", (obsArLen.size() > 0) ? 32'(obsArLen[0]) : 32'hFFFF_FFFF, 32'(tbl[i].ar0Len));
         end
         if (tbl[i].nBursts > 1) begin
            checkOutput("tbl_ar1_addr", (obsArAddr.size() > 1) ? obsArAddr[1] : 32'hFFFF_FFFF, tbl[i].ar1Addr);
            checkOutput("tbl_ar1_len", (obsArLen.size() > 1) ? 32'(obsArLen[1]) : 32'hFFFF_FFFF, 32'(tbl[i].ar1Len));
         end
      end

      curTag = "reset_mid_data";
      applyStimulus(32'h0000_0000, 20'd1500, 0, 10, -1, 100);
      curTag = "after_reset";
      applyStimulus(32'h0000_7000, 20'd12, 0, 0, -1, -1);

      for (int i = 0; i < 8; i++) begin
         logic [31:0] rAddr;
         logic [19:0] rLen;
         rAddr = 32'($urandom_range(0, 8191)) * 32'd4;
         rLen = 20'($urandom_range(0, 2100));
         curTag = $sformatf("random%0d a=%08h l=%0d", i, rAddr, rLen);
         applyStimulus(rAddr, rLen, int'($urandom_range(0, 3)), 30, -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/simple_axi_to_axi_read.md
# simple_axi_to_axi_read

Bridges the accelerator's simple read-master interface to an AXI4 read master port; the counterpart of the simple-to-AXI write bridge on the same memory path. A single request carries a word-aligned byte address and a byte length. The block splits it into INCR bursts of at most 256 beats, none crossing a 4 KB boundary, and streams the returned words back beat by beat, flagging the final one.

## Interface
- AXI_ADDR_W, 32, address width (simple and AXI side)
- AXI_DATA_W, 32, data width; only 32 is supported (4-byte beats)
- AXI_LEN_W, 8, AXI arlen width
- AXI_ID_W, 1, AXI id width
- LEN_W, 20, byte-length width of a simple request

Ports:
- Clock and reset: one clock, `clk_i`. Reset is `rst_i`, asynchronous and active-low.
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous assert, active-low
- m_rvalid_i  in  1  request active; held high until the cycle m_rlast_o is seen
- m_raddr_i  in  AXI_ADDR_W  start byte address; bits [1:0] ignored (treated as 0)
- m_rlen_i  in  LEN_W  request length in bytes
- m_rready_o  out  1  strobe: m_rdata_o valid this cycle; the master must accept it
- m_rdata_o  out  AXI_DATA_W  returned word
- m_rlast_o  out  1  final word of the request
- error_o  out  1  sticky response error; cleared when a new request is accepted
- axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arlock_o[1:0], axi_arcache_o, axi_arprot_o, axi_arqos_o, axi_arvalid_o  out  AR channel
- axi_arready_i  in  1
- axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i  in  R channel
- axi_rready_o  out  1

## Operation
- Constant AR fields: id 0, size 3'b010, burst INCR (2'b01), lock, cache, prot and qos all 0.
- Beat count: beats = ((len-1)>>2)+1, computed at LEN_W width. This is a ceiling division; a trailing partial word is read in full.
- Per-burst beats: n = min(remaining_beats, 256, (4096 - addr[11:0])>>2). axi_arlen_o = n-1.
- After each AR handshake: remaining_beats -= n and addr += 4n.
- States:
  - IDLE: if m_rvalid_i, latch addr and beats, clear error_o, go to CALC.
  - CALC: register araddr and arlen; set arvalid; go to ADDR.
  - ADDR: hold arvalid until axi_arready_i; then update remaining and addr, clear beat counter, go to DATA.
  - DATA: axi_rready_o=1. For each axi_rvalid_i the counter increments. Last burst beat (counter == arlen) → GAP.
  - GAP: one idle cycle (interconnect master switchover). Then IDLE if remaining==0, else CALC.
- Data path: m_rready_o = axi_rvalid_i && DATA. m_rdata_o = axi_rdata_i (combinational pass-through).
- m_rlast_o = m_rready_o && last beat of burst && remaining==0.
- Error: error_o is set by axi_rresp_i != 2'b00 on any beat, or by axi_rlast_i disagreeing with the internal last-beat decision. The transfer always runs to completion on the internal count.
- Length 0: CALC sees beats==0. The block issues no AR and produces one m_rready_o=m_rlast_o=1 pulse with m_rdata_o=0 in GAP, so the master never hangs.

## Timing
- Reset values: all outputs 0 (arvalid, araddr, arlen, rready, m_rready_o, m_rlast_o, error_o); state IDLE.
- Request accepted at cycle t → arvalid asserted at t+2.
- While arvalid is high, araddr and arlen stay stable until arready.
- Beat latency is 0 cycles, R channel to simple side.
- Between bursts: at least 2 idle cycles (GAP, CALC) from the last R beat to the next arvalid.
- m_rvalid_i still high in the cycle after GAP→IDLE is taken as a new request. The master drops it the cycle after m_rlast_o.
- Reset mid-burst: immediate return to IDLE. Outstanding AXI reads are not drained; the interconnect shares the reset.

## Structure
- Shared package holds: state encoding, AXI constants (SIZE_4B, BURST_INCR, RESP_OKAY), MAX_BURST_BEATS=256, BOUNDARY_4K=4096.
- Sub-module simple_axi_read_burst_calc: combinational n and arlen from addr[11:0] and remaining_beats. It is shared in form with the write bridge's boundary logic.

## Test plan
- addr 0x1000, len 16 → one AR (arlen 3); 4 m_rready_o pulses; m_rlast_o only on the 4th.
- addr 0x0, len 1500 → 375 beats. AR arlen 255 @0x0, then arlen 118 @0x400; GAP cycle between; exactly one m_rlast_o.
- addr 0x0FF8, len 32 → AR arlen 1 @0xFF8, then arlen 5 @0x1000.
- len 6 → arlen 1, 2 beats. len 0 → no AR; one m_rready_o+m_rlast_o pulse with data 0.
- arready delayed 5 cycles, random rvalid gaps → araddr/arlen stable while pending; m_rdata_o matches memory model word for word.
- rresp SLVERR on beat 2 → error_o=1 persists to the end, cleared on the next request. Separately, reset mid-DATA → all outputs return to 0, state IDLE.
